// File: rtl/scaler_div_arbiter_pkg.sv
// Constants shared by the scaler divider arbiter and the scaler config generation.
// Holds the 2-bit FSM encodings, the default quotient width and the saturation value.
package scaler_div_arbiter_pkg;

    localparam int DIVIDEND_WIDTH_DEF = 18;
    localparam logic [DIVIDEND_WIDTH_DEF-1:0] QUOT_SAT = '1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_START  = 2'd1,
        ST_BUSY   = 2'd2,
        ST_RESULT = 2'd3
    } state_t;

endpackage

// File: rtl/scaler_div_arbiter_serial_divide.sv
// serial_divide: restoring divider, one quotient bit per cycle.
// done_o pulses DIVIDEND_WIDTH+1 cycles after the divide_cmd_i cycle.
module serial_divide #(
    parameter int DIVIDEND_WIDTH = 18,
    parameter int DIVISOR_WIDTH  = 12
) (
    input  logic                      clk,
    input  logic                      nrst_i,
    input  logic                      divide_cmd_i,
    input  logic [DIVIDEND_WIDTH-1:0] dividend_i,
    input  logic [DIVISOR_WIDTH-1:0]  divisor_i,
    output logic                      done_o,
    output logic [DIVIDEND_WIDTH-1:0] quotient_o
);
    localparam int CW = $clog2(DIVIDEND_WIDTH + 1);

    logic [DIVISOR_WIDTH-1:0]  rem_q, rem_d, dsr_q, dsr_d;
    logic [DIVIDEND_WIDTH-1:0] quo_q, quo_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic                      done_q, done_d;
    logic [DIVISOR_WIDTH:0]    shifted, diff;

    always_comb begin
        rem_d   = rem_q;
        quo_d   = quo_q;
        dsr_d   = dsr_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        shifted = {rem_q, quo_q[DIVIDEND_WIDTH-1]};
        diff    = shifted - {1'b0, dsr_q};
        if (divide_cmd_i) begin
            rem_d = '0;
            quo_d = dividend_i;
            dsr_d = divisor_i;
            cnt_d = CW'(DIVIDEND_WIDTH);
        end else if (cnt_q != '0) begin
            cnt_d  = cnt_q - CW'(1);
            done_d = (cnt_q == CW'(1));
            // Remainder stays below the divisor, so the top bit is dropped safely.
            if (shifted >= {1'b0, dsr_q}) begin
                rem_d = diff[DIVISOR_WIDTH-1:0];
                quo_d = {quo_q[DIVIDEND_WIDTH-2:0], 1'b1};
            end else begin
                rem_d = shifted[DIVISOR_WIDTH-1:0];
                quo_d = {quo_q[DIVIDEND_WIDTH-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst_i) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dsr_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dsr_q  <= dsr_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign done_o     = done_q;
    assign quotient_o = quo_q;

endmodule

// File: rtl/scaler_div_arbiter.sv
// Round-robin share of one serial_divide between vertical and horizontal scaler requesters.
// SCALER_DIV_TIMEOUT_EN adds a BUSY watchdog and the sticky err_o port.
module scaler_div_arbiter
    import scaler_div_arbiter_pkg::*;
#(
    parameter int DIVIDEND_WIDTH = DIVIDEND_WIDTH_DEF,
    parameter int V_DIVISOR_W    = 11,
    parameter int H_DIVISOR_W    = 12
`ifdef SCALER_DIV_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 48
`endif
) (
    input  logic                      SYS_CLK,
    input  logic                      nRST,
    input  logic                      v_req_i,
    input  logic [V_DIVISOR_W-1:0]    v_divisor_i,
    output logic                      v_done_o,
    output logic [DIVIDEND_WIDTH-1:0] v_quotient_o,
    input  logic                      h_req_i,
    input  logic [H_DIVISOR_W-1:0]    h_divisor_i,
    output logic                      h_done_o,
    output logic [DIVIDEND_WIDTH-1:0] h_quotient_o,
    output logic                      busy_o,
    output logic                      grant_h_o
`ifdef SCALER_DIV_TIMEOUT_EN
    , output logic                    err_o
`endif
);
    state_t                    state_q, state_d;
    logic                      owner_h_q, owner_h_d, last_h_q, last_h_d, mask_q, mask_d;
    logic [H_DIVISOR_W-1:0]    div_q, div_d;
    logic [DIVIDEND_WIDTH-1:0] v_quot_q, v_quot_d, h_quot_q, h_quot_d, res_val;
    logic                      v_done_q, v_done_d, h_done_q, h_done_d;
    logic                      v_eff, h_eff, res_load, div_cmd, div_done;
    logic [DIVIDEND_WIDTH-1:0] div_quot;
`ifdef SCALER_DIV_TIMEOUT_EN
    logic [5:0]                tmr_q, tmr_d;
    logic                      err_q, err_d;
`endif

    serial_divide #(
        .DIVIDEND_WIDTH(DIVIDEND_WIDTH),
        .DIVISOR_WIDTH (H_DIVISOR_W)
    ) u_div (
        .clk         (SYS_CLK),
        .nrst_i      (nRST),
        .divide_cmd_i(div_cmd),
        .dividend_i  ({1'b1, {(DIVIDEND_WIDTH-1){1'b0}}}),
        .divisor_i   (div_q),
        .done_o      (div_done),
        .quotient_o  (div_quot)
    );

    always_comb begin
        state_d   = state_q;
        owner_h_d = owner_h_q;
        last_h_d  = last_h_q;
        mask_d    = 1'b0;
        div_d     = div_q;
        v_quot_d  = v_quot_q;
        h_quot_d  = h_quot_q;
        v_done_d  = 1'b0;
        h_done_d  = 1'b0;
        div_cmd   = 1'b0;
        res_load  = 1'b0;
        res_val   = div_quot;
`ifdef SCALER_DIV_TIMEOUT_EN
        tmr_d     = tmr_q;
        err_d     = err_q;
`endif
        // The requester just served still holds req for one IDLE cycle.
        v_eff = v_req_i && !(mask_q && !owner_h_q);
        h_eff = h_req_i && !(mask_q && owner_h_q);
        case (state_q)
            ST_IDLE: begin
                if (v_eff || h_eff) begin
                    if (v_eff && h_eff) owner_h_d = !last_h_q;
                    else                owner_h_d = h_eff;
                    div_d   = owner_h_d ? h_divisor_i : H_DIVISOR_W'(v_divisor_i);
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (div_q == '0) begin
                    res_val  = QUOT_SAT;
                    res_load = 1'b1;
                end else begin
                    div_cmd = 1'b1;
                    state_d = ST_BUSY;
`ifdef SCALER_DIV_TIMEOUT_EN
                    tmr_d   = 6'(TIMEOUT_CYCLES - 1);
`endif
                end
            end
            ST_BUSY: begin
                if (div_done) begin
                    res_load = 1'b1;
                end
`ifdef SCALER_DIV_TIMEOUT_EN
                else if (tmr_q == '0) begin
                    res_val  = QUOT_SAT;
                    res_load = 1'b1;
                    err_d    = 1'b1;
                end else begin
                    tmr_d = tmr_q - 6'd1;
                end
`endif
            end
            ST_RESULT: begin
                last_h_d = owner_h_q;
                mask_d   = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Quotient and done are loaded together so both are visible in RESULT.
        if (res_load) begin
            state_d = ST_RESULT;
            if (owner_h_q) begin
                h_quot_d = res_val;
                h_done_d = 1'b1;
            end else begin
                v_quot_d = res_val;
                v_done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge SYS_CLK) begin
        if (!nRST) begin
            state_q   <= ST_IDLE;
            owner_h_q <= 1'b0;
            last_h_q  <= 1'b1;
            mask_q    <= 1'b0;
            div_q     <= '0;
            v_quot_q  <= '0;
            h_quot_q  <= '0;
            v_done_q  <= 1'b0;
            h_done_q  <= 1'b0;
`ifdef SCALER_DIV_TIMEOUT_EN
            tmr_q     <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            owner_h_q <= owner_h_d;
            last_h_q  <= last_h_d;
            mask_q    <= mask_d;
            div_q     <= div_d;
            v_quot_q  <= v_quot_d;
            h_quot_q  <= h_quot_d;
            v_done_q  <= v_done_d;
            h_done_q  <= h_done_d;
`ifdef SCALER_DIV_TIMEOUT_EN
            tmr_q     <= tmr_d;
            err_q     <= err_d;
`endif
        end
    end

    assign v_done_o     = v_done_q;
    assign h_done_o     = h_done_q;
    assign v_quotient_o = v_quot_q;
    assign h_quotient_o = h_quot_q;
    assign busy_o       = (state_q != ST_IDLE);
    assign grant_h_o    = owner_h_q;
`ifdef SCALER_DIV_TIMEOUT_EN
    assign err_o        = err_q;
`endif

endmodule

// File: tb/tb_scaler_div_arbiter.sv
// Scoreboard bench for scaler_div_arbiter: requesters push expected quotients, a monitor pops on done.
module tb_scaler_div_arbiter;
    logic        clk = 1'b0;
    logic        nrst;
    logic        v_req, h_req;
    logic [10:0] v_div;
    logic [11:0] h_div;
    logic        v_done, h_done, busy, grant_h;
    logic [17:0] v_quot, h_quot;
`ifdef SCALER_DIV_TIMEOUT_EN
    logic        err;
`endif

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cmd_cnt  = 0;
    int          v_done_cnt = 0;
    logic [17:0] v_exp_q[$];
    logic [17:0] h_exp_q[$];

    localparam int WAIT_LIMIT = 200;

    always #5 clk = ~clk;

    scaler_div_arbiter dut (
        .SYS_CLK     (clk),
        .nRST        (nrst),
        .v_req_i     (v_req),
        .v_divisor_i (v_div),
        .v_done_o    (v_done),
        .v_quotient_o(v_quot),
        .h_req_i     (h_req),
        .h_divisor_i (h_div),
        .h_done_o    (h_done),
        .h_quotient_o(h_quot),
        .busy_o      (busy),
        .grant_h_o   (grant_h)
`ifdef SCALER_DIV_TIMEOUT_EN
        , .err_o     (err)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        logic [17:0] e;
        if (dut.div_cmd) cmd_cnt++;
        if (v_done) begin
            v_done_cnt++;
            if (v_exp_q.size() == 0) begin
                chk("v_done_unexpected", 32'd1, 32'd0);
            end else begin
                e = v_exp_q.pop_front();
                chk("v_quotient", 32'(v_quot), 32'(e));
                chk("v_grant", 32'(grant_h), 32'd0);
            end
        end
        if (h_done) begin
            if (h_exp_q.size() == 0) begin
                chk("h_done_unexpected", 32'd1, 32'd0);
            end else begin
                e = h_exp_q.pop_front();
                chk("h_quotient", 32'(h_quot), 32'(e));
                chk("h_grant", 32'(grant_h), 32'd1);
            end
        end
    end

    // Called at a negedge; returns the number of rising edges until done is seen.
    // The requester holds req through the masked IDLE cycle, then drops it.
    task automatic req_v(input logic [10:0] d, input logic [17:0] q, output int lat);
        v_exp_q.push_back(q);
        v_div = d;
        v_req = 1'b1;
        lat = 0;
        while (!v_done && lat < WAIT_LIMIT) begin
            @(negedge clk);
            lat++;
        end
        n_checks++;
        if (lat >= WAIT_LIMIT) begin
            n_fail++;
            $display("FAIL v_wait_timeout: no v_done after %0d cycles, expected one", lat);
        end
        @(posedge clk);
        @(posedge clk);
        #1 v_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic req_h(input logic [11:0] d, input logic [17:0] q, output int lat);
        h_exp_q.push_back(q);
        h_div = d;
        h_req = 1'b1;
        lat = 0;
        while (!h_done && lat < WAIT_LIMIT) begin
            @(negedge clk);
            lat++;
        end
        n_checks++;
        if (lat >= WAIT_LIMIT) begin
            n_fail++;
            $display("FAIL h_wait_timeout: no h_done after %0d cycles, expected one", lat);
        end
        @(posedge clk);
        @(posedge clk);
        #1 h_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        nrst = 1'b0;
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int lv, lh, snap;
        nrst  = 1'b0;
        v_req = 1'b0;
        h_req = 1'b0;
        v_div = '0;
        h_div = '0;
        do_reset();
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_grant", 32'(grant_h), 32'd0);
        chk("reset_v_quot", 32'(v_quot), 32'd0);
        chk("reset_h_quot", 32'(h_quot), 32'd0);
        chk("reset_dones", 32'({v_done, h_done}), 32'd0);

        // Single V job, then single H job
        req_v(11'd480, 18'd273, lv);
        chk("v480_latency", 32'(lv), 32'd21);
        chk("v480_h_untouched", 32'(h_quot), 32'd0);
        chk("v480_busy_after", 32'(busy), 32'd0);
        req_h(12'd1280, 18'd102, lh);
        chk("h1280_latency", 32'(lh), 32'd21);
        chk("h1280_grant_held", 32'(grant_h), 32'd1);
        chk("h1280_v_held", 32'(v_quot), 32'd273);

        // Tie straight after reset: V wins, H follows after the masked cycle
        do_reset();
        fork
            req_v(11'd480, 18'd273, lv);
            req_h(12'd1280, 18'd102, lh);
        join
        chk("tie1_v_latency", 32'(lv), 32'd21);
        chk("tie1_h_latency", 32'(lh), 32'd43);
        // Serve V alone, so the next tie goes to H
        req_v(11'd2047, 18'd64, lv);
        fork
            req_v(11'd720, 18'd182, lv);
            req_h(12'd4095, 18'd32, lh);
        join
        chk("tie2_h_latency", 32'(lh), 32'd21);
        chk("tie2_v_latency", 32'(lv), 32'd43);

        // Boundary divisors
        snap = cmd_cnt;
        req_v(11'd0, 18'h3FFFF, lv);
        chk("v0_latency", 32'(lv), 32'd2);
        chk("v0_no_div_cmd", 32'(cmd_cnt - snap), 32'd0);
        req_h(12'd1, 18'd131072, lh);
        chk("h1_latency", 32'(lh), 32'd21);
        chk("h1_div_cmd_once", 32'(cmd_cnt - snap), 32'd1);

        // Reset in the middle of BUSY aborts the job
        v_div = 11'd480;
        v_req = 1'b1;
        repeat (6) @(negedge clk);
        chk("midbusy_busy", 32'(busy), 32'd1);
        nrst = 1'b0;
        @(negedge clk);
        v_req = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_v_quot", 32'(v_quot), 32'd0);
        chk("abort_h_quot", 32'(h_quot), 32'd0);
        chk("abort_grant", 32'(grant_h), 32'd0);
        chk("abort_dones", 32'({v_done, h_done}), 32'd0);
        nrst = 1'b1;
        snap = v_done_cnt;
        repeat (30) @(negedge clk);
        chk("abort_no_done", 32'(v_done_cnt - snap), 32'd0);
        req_v(11'd720, 18'd182, lv);
        chk("post_abort_latency", 32'(lv), 32'd21);

`ifdef SCALER_DIV_TIMEOUT_EN
        chk("err_clear", 32'(err), 32'd0);
        force dut.div_done = 1'b0;
        req_v(11'd480, 18'h3FFFF, lv);
        release dut.div_done;
        chk("timeout_latency", 32'(lv), 32'd50);
        chk("timeout_err", 32'(err), 32'd1);
        req_h(12'd1280, 18'd102, lh);
        chk("err_sticky", 32'(err), 32'd1);
        do_reset();
        chk("err_reset", 32'(err), 32'd0);
`endif

        repeat (5) @(negedge clk);
        chk("v_scoreboard_empty", 32'(v_exp_q.size()), 32'd0);
        chk("h_scoreboard_empty", 32'(h_exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
